// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter in front of a registered 4:1 data mux. Four sources
// compete for a single output register that is drained through a
// valid/ready stream. A source may keep winning for up to MAX_BURST
// back-to-back captures while others wait. A lone requester wins every cycle.

module rr_mux_arbiter_4 #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_BURST = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [3:0]           i_req,
   input  logic [4*WIDTH-1:0]   i_in_data,
   output logic [3:0]           o_gnt,
   output logic                 o_out_valid,
   input  logic                 i_out_ready,
   output logic [WIDTH-1:0]     o_out_data,
   output logic [1:0]           o_out_sel
);

   localparam int unsigned     CntW   = $clog2(MAX_BURST + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);

   typedef enum logic {StEmpty, StFull} state_e;

   state_e              r_state;
   state_e              w_state_nxt;
   logic [1:0]          r_ptr;
   logic [CntW-1:0]     r_burst_cnt;
   logic [CntW-1:0]     w_burst_nxt;
   logic                r_last_cap;
   logic [WIDTH-1:0]    r_out_data;
   logic [1:0]          r_out_sel;

   logic                w_slot_free;
   logic                w_capture;
   logic                w_hold;
   logic [1:0]          w_winner;
   logic [WIDTH-1:0]    w_mux_data;

   // The slot is free when empty or when the held word leaves at this edge.
   // Grants are suppressed while reset is asserted.
   assign w_slot_free = (r_state == StEmpty) || i_out_ready;
   assign w_capture   = rst_n && w_slot_free && (|i_req);

   // The current owner keeps the slot only if it captured last cycle,
   // still requests, and has burst budget left.
   assign w_hold = (r_burst_cnt < MaxCnt) && i_req[r_ptr] && r_last_cap;

   // Winner selection: burst continuation first, else rotate from ptr+1.
   always_comb begin
      w_winner = r_ptr;
      // Walk from lowest to highest priority so the closest requester wins.
      for (int i = 4; i >= 1; i--) begin
         if (i_req[r_ptr + 2'(i)]) begin
            w_winner = r_ptr + 2'(i);
         end
      end
      if (w_hold) begin
         w_winner = r_ptr;
      end
   end

   // Steer the winning source onto the register input.
   always_comb begin
      w_mux_data = '0;
      for (int i = 0; i < 4; i++) begin
         if (w_winner == 2'(i)) begin
            w_mux_data = i_in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // One-hot grant, only when a capture happens at the coming edge.
   always_comb begin
      o_gnt = 4'b0000;
      if (w_capture) begin
         o_gnt = 4'b0001 << w_winner;
      end
   end

   // Consecutive-grant count; restarts at 1 when ownership moves.
   always_comb begin
      w_burst_nxt = CntW'(1);
      if (w_winner == r_ptr) begin
         if (r_burst_cnt == MaxCnt) begin
            w_burst_nxt = r_burst_cnt;
         end else begin
            w_burst_nxt = r_burst_cnt + CntW'(1);
         end
      end
   end

   // Output register occupancy FSM next-state.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StEmpty: begin
            if (w_capture) begin
               w_state_nxt = StFull;
            end
         end
         StFull: begin
            if (w_capture) begin
               w_state_nxt = StFull;
            end else if (i_out_ready) begin
               w_state_nxt = StEmpty;
            end
         end
         default: w_state_nxt = StEmpty;
      endcase
   end

   // Occupancy state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StEmpty;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Arbitration state: pointer, burst count and capture continuity.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr       <= 2'd3;
         r_burst_cnt <= '0;
         r_last_cap  <= 1'b0;
      end else begin
         r_last_cap <= w_capture;
         if (w_capture) begin
            r_ptr       <= w_winner;
            r_burst_cnt <= w_burst_nxt;
         end
      end
   end

   // Output data/select register; holds across drains and stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data <= '0;
         r_out_sel  <= 2'd0;
      end else if (w_capture) begin
         r_out_data <= w_mux_data;
         r_out_sel  <= w_winner;
      end
   end

   assign o_out_valid = (r_state == StFull);
   assign o_out_data  = r_out_data;
   assign o_out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Bench for rr_mux_arbiter_4: two instances (MAX_BURST=1 and 2) share stimulus
// and are compared against a behavioural model of the arbitration rules.

module tb_rr_mux_arbiter_4;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] in_data;
   logic        ready;

   logic [3:0]  gnt_a, gnt_b;
   logic        valid_a, valid_b;
   logic [7:0]  data_a, data_b;
   logic [1:0]  sel_a, sel_b;

   logic [3:0]  d_gnt   [2];
   logic        d_valid [2];
   logic [7:0]  d_data  [2];
   logic [1:0]  d_sel   [2];

   assign d_gnt[0] = gnt_a;     assign d_gnt[1] = gnt_b;
   assign d_valid[0] = valid_a; assign d_valid[1] = valid_b;
   assign d_data[0] = data_a;   assign d_data[1] = data_b;
   assign d_sel[0] = sel_a;     assign d_sel[1] = sel_b;

   int n_err = 0;
   int n_chk = 0;

   rr_mux_arbiter_4 #(.WIDTH(8), .MAX_BURST(1)) dut_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_req       (req),
      .i_in_data   (in_data),
      .o_gnt       (gnt_a),
      .o_out_valid (valid_a),
      .i_out_ready (ready),
      .o_out_data  (data_a),
      .o_out_sel   (sel_a)
   );

   rr_mux_arbiter_4 #(.WIDTH(8), .MAX_BURST(2)) dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_req       (req),
      .i_in_data   (in_data),
      .o_gnt       (gnt_b),
      .o_out_valid (valid_b),
      .i_out_ready (ready),
      .o_out_data  (data_b),
      .o_out_sel   (sel_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state, one entry per instance.
   int          m_ptr   [2];
   int          m_run   [2];  // consecutive captures by the last winner
   bit          m_cont  [2];  // previous cycle captured
   bit          m_valid [2];
   logic [7:0]  m_data  [2];
   int          m_sel   [2];

   function automatic int max_burst(input int k);
      return (k == 0) ? 1 : 2;
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         m_ptr[k] = 3; m_run[k] = 0; m_cont[k] = 0;
         m_valid[k] = 0; m_data[k] = 8'h00; m_sel[k] = 0;
      end
   endfunction

   // Winner index, or -1 when nobody requests.
   function automatic int pick(input int k);
      if (m_run[k] < max_burst(k) && req[m_ptr[k]] && m_cont[k]) return m_ptr[k];
      for (int off = 1; off <= 4; off++) begin
         if (req[(m_ptr[k] + off) % 4]) return (m_ptr[k] + off) % 4;
      end
      return -1;
   endfunction

   function automatic bit will_capture(input int k);
      return rst_n && (!m_valid[k] || ready) && (req != 4'b0000);
   endfunction

   function automatic logic [3:0] m_gnt(input int k);
      logic [3:0] g;
      g = 4'b0000;
      if (will_capture(k)) g[pick(k)] = 1'b1;
      return g;
   endfunction

   // Advance the model across one rising edge using the inputs held before it.
   function automatic void model_clock();
      int w;
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int k = 0; k < 2; k++) begin
         if (will_capture(k)) begin
            w = pick(k);
            if (w == m_ptr[k]) m_run[k] = (m_run[k] + 1 > max_burst(k)) ? max_burst(k) : m_run[k] + 1;
            else m_run[k] = 1;
            m_ptr[k] = w;
            m_data[k] = in_data[w*8 +: 8];
            m_sel[k] = w;
            m_valid[k] = 1;
            m_cont[k] = 1;
         end else begin
            if (ready) m_valid[k] = 0;
            m_cont[k] = 0;
         end
      end
   endfunction

   // One clock: edge, new inputs shortly after, return at the falling edge.
   task automatic cycle(input logic [3:0] r, input logic [31:0] d, input logic rdy);
      @(posedge clk);
      model_clock();
      #1;
      req = r; in_data = d; ready = rdy;
      @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0; req = 4'b0000; ready = 1'b0; in_data = '0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      for (int k = 0; k < 2; k++) begin
         n_chk++;
         if (d_valid[k] !== 1'b0 || d_data[k] !== 8'h00 || d_sel[k] !== 2'd0 || d_gnt[k] !== 4'b0000) begin
            n_err++;
            $display("FAIL reset[%0d]: got v=%b d=%h s=%0d g=%b want v=0 d=00 s=0 g=0000",
                     k, d_valid[k], d_data[k], d_sel[k], d_gnt[k]);
         end
      end
   endtask

   task automatic test_single();
      apply_reset();
      cycle(4'b0100, 32'h00A5_0000, 1'b1);
      n_chk++;
      if (gnt_a !== 4'b0100) begin
         n_err++; $display("FAIL single_gnt: got %b want 0100", gnt_a);
      end
      cycle(4'b0000, 32'h0, 1'b1);
      n_chk++;
      if (valid_a !== 1'b1 || data_a !== 8'hA5 || sel_a !== 2'd2) begin
         n_err++;
         $display("FAIL single_out: got v=%b d=%h s=%0d want v=1 d=a5 s=2", valid_a, data_a, sel_a);
      end
   endtask

   task automatic test_rr_burst1();
      int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
      apply_reset();
      cycle(4'b1111, 32'h4433_2211, 1'b1);
      for (int i = 0; i < 6; i++) begin
         cycle(4'b1111, 32'h4433_2211, 1'b1);
         n_chk++;
         if (valid_a !== 1'b1 || sel_a !== 2'(exp_seq[i])) begin
            n_err++;
            $display("FAIL rr1_sel[%0d]: got v=%b s=%0d want v=1 s=%0d", i, valid_a, sel_a, exp_seq[i]);
         end
      end
   endtask

   task automatic test_burst2();
      int exp_seq [6] = '{0, 0, 1, 1, 0, 0};
      apply_reset();
      cycle(4'b0011, 32'h0000_BBAA, 1'b1);
      for (int i = 0; i < 6; i++) begin
         cycle(4'b0011, 32'h0000_BBAA, 1'b1);
         n_chk++;
         if (sel_b !== 2'(exp_seq[i])) begin
            n_err++; $display("FAIL burst2_sel[%0d]: got %0d want %0d", i, sel_b, exp_seq[i]);
         end
         n_chk++;
         if (sel_a !== 2'(m_sel[0])) begin
            n_err++; $display("FAIL burst1_sel[%0d]: got %0d want %0d", i, sel_a, m_sel[0]);
         end
      end
   endtask

   task automatic test_stall();
      apply_reset();
      cycle(4'b1000, 32'h3C00_0000, 1'b0);
      n_chk++;
      if (gnt_a !== 4'b1000) begin
         n_err++; $display("FAIL stall_first_gnt: got %b want 1000", gnt_a);
      end
      for (int i = 0; i < 5; i++) begin
         cycle(4'b1000, 32'h7700_0000, 1'b0);
         n_chk++;
         if (gnt_a !== 4'b0000 || gnt_b !== 4'b0000 || valid_a !== 1'b1 || data_a !== 8'h3C) begin
            n_err++;
            $display("FAIL stall_hold[%0d]: got ga=%b gb=%b v=%b d=%h want 0000 0000 1 3c",
                     i, gnt_a, gnt_b, valid_a, data_a);
         end
      end
      cycle(4'b1000, 32'h7700_0000, 1'b1);
      n_chk++;
      if (gnt_a !== 4'b1000 || gnt_b !== 4'b1000) begin
         n_err++; $display("FAIL stall_release_gnt: got %b %b want 1000", gnt_a, gnt_b);
      end
      cycle(4'b0000, 32'h0, 1'b1);
      n_chk++;
      if (valid_a !== 1'b1 || data_a !== 8'h77 || sel_a !== 2'd3) begin
         n_err++;
         $display("FAIL stall_next_word: got v=%b d=%h s=%0d want 1 77 3", valid_a, data_a, sel_a);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      cycle(4'b0100, 32'h0055_0000, 1'b0);
      cycle(4'b0000, 32'h0, 1'b0);
      n_chk++;
      if (valid_a !== 1'b1) begin
         n_err++; $display("FAIL rstmid_pre_valid: got %b want 1", valid_a);
      end
      rst_n = 1'b0; req = 4'b1001; in_data = 32'h1100_0022;
      #1;
      model_reset();
      for (int k = 0; k < 2; k++) begin
         n_chk++;
         if (d_valid[k] !== 1'b0 || d_data[k] !== 8'h00 || d_gnt[k] !== 4'b0000) begin
            n_err++;
            $display("FAIL rstmid_async[%0d]: got v=%b d=%h g=%b want 0 00 0000",
                     k, d_valid[k], d_data[k], d_gnt[k]);
         end
      end
      #2;
      rst_n = 1'b1; ready = 1'b1;
      #1;
      n_chk++;
      if (gnt_a !== 4'b0001 || gnt_b !== 4'b0001) begin
         n_err++; $display("FAIL rstmid_first_gnt: got %b %b want 0001", gnt_a, gnt_b);
      end
      cycle(4'b0000, 32'h0, 1'b1);
      n_chk++;
      if (data_a !== 8'h22 || sel_a !== 2'd0 || valid_a !== 1'b1) begin
         n_err++; $display("FAIL rstmid_word: got d=%h s=%0d v=%b want 22 0 1", data_a, sel_a, valid_a);
      end
   endtask

   task automatic test_idle_continuity();
      apply_reset();
      cycle(4'b1000, 32'h9900_0000, 1'b1);
      n_chk++;
      if (gnt_a !== 4'b1000) begin
         n_err++; $display("FAIL idle_first_gnt: got %b want 1000", gnt_a);
      end
      repeat (3) cycle(4'b0000, 32'h0, 1'b1);
      cycle(4'b1001, 32'h9900_0011, 1'b1);
      for (int k = 0; k < 2; k++) begin
         n_chk++;
         if (d_gnt[k] !== 4'b0001) begin
            n_err++; $display("FAIL idle_gnt[%0d]: got %b want 0001", k, d_gnt[k]);
         end
      end
   endtask

   task automatic test_random();
      logic [3:0]  r;
      logic [31:0] d;
      logic        rdy;
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         r   = 4'($urandom_range(0, 15));
         d   = $urandom;
         rdy = ($urandom_range(0, 3) != 0);
         cycle(r, d, rdy);
         for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (d_gnt[k] !== m_gnt(k) || d_valid[k] !== m_valid[k] ||
                d_data[k] !== m_data[k] || d_sel[k] !== 2'(m_sel[k])) begin
               n_err++;
               $display("FAIL rand[%0d][%0d]: got g=%b v=%b d=%h s=%0d want g=%b v=%b d=%h s=%0d",
                        i, k, d_gnt[k], d_valid[k], d_data[k], d_sel[k],
                        m_gnt(k), m_valid[k], m_data[k], m_sel[k]);
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; req = 4'b0000; in_data = '0; ready = 1'b0;
      model_reset();
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_single();
      test_rr_burst1();
      test_burst2();
      test_stall();
      test_reset_mid();
      test_idle_continuity();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
